// File: rtl/im_fetch_arb_pkg.sv
// im_fetch_arb_pkg: shared types and constants for the instruction-memory
// fetch/debug arbiter and its burst counter.
package im_fetch_arb_pkg;

  // Default IM address and instruction widths
  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 16;

  // Beat counter holds 1..16, so it needs one bit more than d_len
  localparam int BEAT_W = 5;

  // Arbiter states: fetch owns the port, or a debug burst owns it
  typedef enum logic {
    S_FETCH = 1'b0,
    S_DBG   = 1'b1
  } arb_state_t;

  // Convert a "beats minus one" length field into a beat count
  function automatic logic [BEAT_W-1:0] beats_from_len(input logic [3:0] len);
    return {1'b0, len} + BEAT_W'(1);
  endfunction

endpackage

// File: rtl/im_arb_burst_ctr.sv
// im_arb_burst_ctr: debug burst address pointer and remaining-beat counter.
// Loads base address and beat count on burst accept, then steps the pointer
// (wrapping at the top of the address space) and counts beats down.
module im_arb_burst_ctr
  import im_fetch_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [3:0]        len,
  input  logic              step,
  output logic [ADDR_W-1:0] ptr,
  output logic              last
);

  logic [BEAT_W-1:0] beat_cnt;

  // Load on accept; otherwise advance one address and one beat per burst cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr      <= '0;
      beat_cnt <= '0;
    end else if (load) begin
      ptr      <= base_addr;
      beat_cnt <= beats_from_len(len);
    end else if (step) begin
      ptr      <= ptr + ADDR_W'(1);
      beat_cnt <= beat_cnt - BEAT_W'(1);
    end
  end

  // The beat being issued now is the final one of the burst
  always_comb begin
    last = (beat_cnt == BEAT_W'(1));
  end

endmodule

// File: rtl/im_fetch_arb.sv
// im_fetch_arb: arbitrates the single IM read port between the pipeline fetch
// stage (priority) and a bursting debug/loader port. A starvation counter
// forces the debug port in after STARVE_MAX consecutive waiting cycles.
// Optional build macro IM_FETCH_ARB_PERF_EN enables the fetch-stall counter;
// without it perf_stall_cnt is tied to zero.
module im_fetch_arb
  import im_fetch_arb_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int STARVE_MAX = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_gnt,
  output logic              f_rvalid,
  output logic [DATA_W-1:0] f_instr,
  input  logic              d_req,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [3:0]        d_len,
  output logic              d_busy,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_done,
  output logic [ADDR_W-1:0] im_addr,
  output logic              im_rd_en,
  input  logic [DATA_W-1:0] im_instr,
  output logic [31:0]       perf_stall_cnt
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  arb_state_t        state;
  arb_state_t        next_state;
  logic [3:0]        wait_cnt;
  logic              accept;
  logic              in_dbg;
  logic [ADDR_W-1:0] d_ptr;
  logic              beat_last;

  // Burst pointer and beat counter, loaded on accept and stepped while bursting
  im_arb_burst_ctr #(
    .ADDR_W(ADDR_W)
  ) u_burst_ctr (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .base_addr(d_addr),
    .len      (d_len),
    .step     (in_dbg),
    .ptr      (d_ptr),
    .last     (beat_last)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_FETCH;
    end else begin
      state <= next_state;
    end
  end

  // Next state and IM port steering; the accept cycle still serves fetch
  always_comb begin
    next_state = state;
    im_addr    = f_addr;
    im_rd_en   = 1'b0;
    f_gnt      = 1'b0;
    accept     = 1'b0;
    in_dbg     = 1'b0;
    case (state)
      S_FETCH: begin
        im_rd_en = f_req;
        f_gnt    = f_req;
        if (d_req && (!f_req || (wait_cnt == STARVE_LIM))) begin
          accept     = 1'b1;
          next_state = S_DBG;
        end
      end
      S_DBG: begin
        in_dbg   = 1'b1;
        im_addr  = d_ptr;
        im_rd_en = 1'b1;
        if (beat_last) begin
          next_state = S_FETCH;
        end
      end
      default: begin
        next_state = S_FETCH;
      end
    endcase
  end

  // Count consecutive cycles the debug port waits while fetch keeps the port
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if ((state == S_FETCH) && d_req && !accept) begin
      if (wait_cnt != 4'hF) begin
        wait_cnt <= wait_cnt + 4'd1;
      end
    end else begin
      wait_cnt <= '0;
    end
  end

  // Busy flag covers exactly the cycles the burst owns the port
  always_ff @(posedge clk) begin
    if (rst) begin
      d_busy <= 1'b0;
    end else begin
      d_busy <= (next_state == S_DBG);
    end
  end

  // Return read data one cycle after issue to whichever side issued it
  always_ff @(posedge clk) begin
    if (rst) begin
      f_rvalid <= 1'b0;
      f_instr  <= '0;
      d_rvalid <= 1'b0;
      d_rdata  <= '0;
      d_done   <= 1'b0;
    end else begin
      f_rvalid <= f_gnt;
      if (f_gnt) begin
        f_instr <= im_instr;
      end
      d_rvalid <= in_dbg;
      if (in_dbg) begin
        d_rdata <= im_instr;
      end
      d_done <= in_dbg && beat_last;
    end
  end

`ifdef IM_FETCH_ARB_PERF_EN
  // Count cycles where fetch wanted the port but was held off by debug
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_cnt <= '0;
    end else if (f_req && !f_gnt) begin
      perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`else
  assign perf_stall_cnt = '0;
`endif

endmodule

// File: doc/im_fetch_arb.md
Name: im_fetch_arb

Overview:
- Arbitrates the single read port of the 16-bit instruction memory between two requesters:
  - the pipeline fetch stage;
  - a debug/loader read port that issues bursts.
- Fetch has priority. A starvation counter guarantees the debug port is served.
- Read data from the IM (memory latched while clk is low) is registered at the next rising edge and returned to the winning requester.

Parameters:
- ADDR_W, 16, IM address width
- DATA_W, 16, instruction width
- STARVE_MAX, 8, consecutive debug wait cycles before the debug port is forced in (1..15)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- f_req  in  1  fetch wants instruction at f_addr this cycle
- f_addr  in  ADDR_W  fetch PC
- f_gnt  out  1  fetch read issued this cycle (comb); low means stall
- f_rvalid  out  1  f_instr valid (registered)
- f_instr  out  DATA_W  fetched instruction
- d_req  in  1  debug burst request
- d_addr  in  ADDR_W  burst base address
- d_len  in  4  beats minus 1 (1..16 beats)
- d_busy  out  1  burst accepted/in progress
- d_rvalid  out  1  d_rdata valid
- d_rdata  out  DATA_W  burst read data
- d_done  out  1  one-cycle pulse coincident with last d_rvalid
- im_addr  out  ADDR_W  IM address
- im_rd_en  out  1  IM read enable
- im_instr  in  DATA_W  IM read data
- perf_stall_cnt  out  32  fetch cycles stalled by debug

Behaviour:
- States: S_FETCH, S_DBG. Reset -> S_FETCH.
- Reset values: wait_cnt=0, beat_cnt=0, d_ptr=0. All registered outputs are 0: f_rvalid, f_instr, d_rvalid, d_rdata, d_done, perf_stall_cnt.
- S_FETCH:
  - im_addr=f_addr; im_rd_en=f_req; f_gnt=f_req.
  - Accept debug when d_req && (!f_req || wait_cnt==STARVE_MAX). On accept: latch d_ptr=d_addr, beat_cnt=d_len+1; next state S_DBG.
  - The accept cycle still serves fetch if f_req.
  - wait_cnt increments (saturating) each cycle d_req is high and not accepted. It clears on accept or when d_req is low.
- S_DBG:
  - im_addr=d_ptr; im_rd_en=1; f_gnt=0 regardless of f_req.
  - Each cycle: d_ptr+=1, wrapping 16'hFFFF->0; beat_cnt-=1.
  - When beat_cnt==1, next state is S_FETCH.
- d_busy: registered. High from the cycle after accept through the last beat cycle.
- d_req is ignored while d_busy or during the accept cycle.
- Latency: read issued in cycle N -> rvalid/data in cycle N+1.
  - f_rvalid<=f_gnt; f_instr<=im_instr when f_gnt (else holds).
  - d_rvalid<=(state==S_DBG); d_rdata likewise.
  - d_done<=(state==S_DBG && beat_cnt==1).
- Fetch must hold f_addr while f_gnt=0. The arbiter does not buffer requests.
- Reset mid-burst: the burst is aborted; no d_done; S_FETCH next cycle; in-flight rvalids are cleared.
- When f_req is low in S_FETCH, no read is issued; f_rvalid=0 next cycle.

Optional Feature:
- IM_FETCH_ARB_PERF_EN
  - Defined: perf_stall_cnt increments (wrapping at 2^32) each cycle with f_req && !f_gnt. It clears on rst.
  - Undefined: the counter logic is removed; perf_stall_cnt is tied to 0. The port is present in both builds.

Decomposition:
- Package im_fetch_arb_pkg holds:
  - state enum (S_FETCH, S_DBG);
  - ADDR_W/DATA_W defaults;
  - the beat count width constant (5 bits).
- One natural sub-module: im_arb_burst_ctr, the d_ptr/beat_cnt load-decrement-wrap counter with a last-beat flag.

Test Plan:
- Sequential fetch: rst, then f_req=1 with f_addr 0x0000..0x0003 on consecutive cycles, d_req=0. Required: f_gnt=1 every cycle; f_rvalid=1 one cycle later with IM[0..3] in order.
- Idle-fetch burst: f_req=0; d_req=1, d_addr=0x0010, d_len=3. Required:
  - d_busy high for 4 cycles;
  - im_addr steps 0x0010..0x0013;
  - 4 d_rvalid beats, d_done on the 4th;
  - f_gnt=0 throughout.
- Starvation: f_req held high; d_req asserted in cycle 0. Required:
  - accept in cycle 8 (fetch still served in cycles 0..8);
  - d_busy from cycle 9; f_gnt=0 during the burst;
  - fetch resumes the cycle after the last beat.
- Wrap: d_addr=0xFFFE, d_len=3. Required: im_addr sequence FFFE, FFFF, 0000, 0001; d_rdata matches.
- Reset mid-burst: rst pulsed during beat 2 of a 16-beat burst. Required:
  - next cycle S_FETCH, d_busy=0;
  - no d_done; d_rvalid=0;
  - f_gnt=f_req.
- Perf (macro defined): 8-cycle starvation case plus a 4-beat burst with f_req high. Required: perf_stall_cnt=4. Macro undefined: perf_stall_cnt stays 0.
